// File: rtl/nanorv32_alu_pkg.sv
// Shared definitions for the multi-cycle NANORV32 ALU.
// Holds the op codes, the FSM state encoding and the shift helper functions.
package nanorv32_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_NOP  = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_SLT  = 4'd10;
    localparam logic [3:0] OP_SLTU = 4'd11;
    localparam logic [3:0] OP_EQ   = 4'd12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int shamt_w(input int dw);
        return $clog2(dw);
    endfunction

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/nanorv32_alu_shift_step.sv
// One iteration of the shifter: moves the value by 0..SHIFT_STEP bits.
// Any op other than SLL/SRL/SRA passes the value through unchanged.
module nanorv32_alu_shift_step
    import nanorv32_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STEP_W     = 1
) (
    input  logic [DATA_WIDTH-1:0] value,
    input  logic [STEP_W-1:0]     amt,
    input  logic [3:0]            op,
    output logic [DATA_WIDTH-1:0] result
);

    always_comb begin
        result = value;
        case (op)
            OP_SLL:  result = value << amt;
            OP_SRL:  result = value >> amt;
            OP_SRA:  result = $signed(value) >>> amt;
            default: result = value;
        endcase
    end

endmodule

// File: rtl/nanorv32_alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/compare ops and an iterative
// shifter, with a valid/ready request channel and a held response channel.
module nanorv32_alu_mc
    import nanorv32_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_porta,
    input  logic [DATA_WIDTH-1:0] req_portb,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_cond
);

    localparam int SHW    = shamt_w(DATA_WIDTH);
    localparam int CW     = SHW + 1;
    localparam int STEP_W = $clog2(SHIFT_STEP) + 1;

    state_e                state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] work_q, work_d;
    logic [CW-1:0]         rem_q, rem_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  cond_q, cond_d;

    logic [SHW-1:0]        sh;
    logic                  start_shift;
    logic [DATA_WIDTH-1:0] alu_data;
    logic                  alu_cond, is_cmp, cmp;
    logic [STEP_W-1:0]     step_amt;
    logic [CW-1:0]         rem_nxt;
    logic [DATA_WIDTH-1:0] shifted;

    assign sh          = req_porta[SHW-1:0];
    assign start_shift = is_shift(req_op) && (sh != '0);

    // Single-cycle datapath; a shift by zero simply returns b.
    always_comb begin
        alu_data = '0;
        is_cmp   = 1'b0;
        cmp      = 1'b0;
        case (req_op)
            OP_ADD:                 alu_data = req_porta + req_portb;
            OP_SUB:                 alu_data = req_portb - req_porta;
            OP_AND:                 alu_data = req_porta & req_portb;
            OP_OR:                  alu_data = req_porta | req_portb;
            OP_XOR:                 alu_data = req_porta ^ req_portb;
            OP_NOT:                 alu_data = ~req_porta;
            OP_NOP:                 alu_data = req_porta;
            OP_SLL, OP_SRL, OP_SRA: alu_data = req_portb;
            OP_SLT:  begin is_cmp = 1'b1; cmp = $signed(req_portb) < $signed(req_porta); end
            OP_SLTU: begin is_cmp = 1'b1; cmp = req_portb < req_porta; end
            OP_EQ:   begin is_cmp = 1'b1; cmp = req_portb == req_porta; end
            default:                alu_data = '0;
        endcase
        if (is_cmp) alu_data = {{(DATA_WIDTH-1){1'b0}}, cmp};
        alu_cond = is_cmp ? cmp : ((req_op <= OP_EQ) && (alu_data == '0));
    end

    always_comb begin
        step_amt = (rem_q > CW'(SHIFT_STEP)) ? STEP_W'(SHIFT_STEP) : STEP_W'(rem_q);
        rem_nxt  = rem_q - CW'(step_amt);
    end

    nanorv32_alu_shift_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .STEP_W     (STEP_W)
    ) u_shift_step (
        .value  (work_q),
        .amt    (step_amt),
        .op     (op_q),
        .result (shifted)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = start_shift ? SHIFT : DONE;
            SHIFT:   if (rem_nxt == '0) state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        res_valid = (state_q == DONE);
        res_data  = data_q;
        res_cond  = cond_q;
    end

    // The last shift step writes the result directly, so DONE follows it.
    always_comb begin
        op_d   = op_q;
        work_d = work_q;
        rem_d  = rem_q;
        data_d = data_q;
        cond_d = cond_q;
        if (state_q == IDLE && req_valid) begin
            op_d = req_op;
            if (start_shift) begin
                work_d = req_portb;
                rem_d  = {1'b0, sh};
            end else begin
                data_d = alu_data;
                cond_d = alu_cond;
            end
        end else if (state_q == SHIFT) begin
            work_d = shifted;
            rem_d  = rem_nxt;
            if (rem_nxt == '0) begin
                data_d = shifted;
                cond_d = (shifted == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= OP_ADD;
            work_q <= '0;
            rem_q  <= '0;
            data_q <= '0;
            cond_q <= 1'b0;
        end else begin
            op_q   <= op_d;
            work_q <= work_d;
            rem_q  <= rem_d;
            data_q <= data_d;
            cond_q <= cond_d;
        end
    end

endmodule

// File: tb/tb_nanorv32_alu_mc.sv
// Bench for nanorv32_alu_mc: two instances (SHIFT_STEP=1 and 8) share the
// request stream; expected results are queued at accept and popped on output.
module tb_nanorv32_alu_mc;
    import nanorv32_alu_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ed;
        logic        ec;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        cond;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  req_op = '0;
    logic [31:0] req_porta = '0;
    logic [31:0] req_portb = '0;
    logic        res_ready = 1'b0;

    logic        req_ready1, res_valid1, res_cond1;
    logic [31:0] res_data1;
    logic        req_ready8, res_valid8, res_cond8;
    logic [31:0] res_data8;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q1[$];
    exp_t q8[$];
    vec_t tbl[16];

    always #5 clk = ~clk;

    nanorv32_alu_mc #(.DATA_WIDTH(32), .SHIFT_STEP(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
        .req_op(req_op), .req_porta(req_porta), .req_portb(req_portb),
        .res_valid(res_valid1), .res_ready(res_ready), .res_data(res_data1),
        .res_cond(res_cond1)
    );

    nanorv32_alu_mc #(.DATA_WIDTH(32), .SHIFT_STEP(8)) dut8 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready8),
        .req_op(req_op), .req_porta(req_porta), .req_portb(req_portb),
        .res_valid(res_valid8), .res_ready(res_ready), .res_data(res_data8),
        .res_cond(res_cond8)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] op, input logic [31:0] a, input int step);
        int sh;
        sh = int'(a[4:0]);
        if (is_shift(op) && sh != 0) return 1 + (sh + step - 1) / step;
        return 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic handshake(input string nm);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({nm, " req_ready1 after hs"}, 32'(req_ready1), 32'd1);
        chk({nm, " req_ready8 after hs"}, 32'(req_ready8), 32'd1);
        chk({nm, " res_valid1 after hs"}, 32'(res_valid1), 32'd0);
        chk({nm, " res_valid8 after hs"}, 32'(res_valid8), 32'd0);
    endtask

    // Drive one request, wait (bounded) for both results, then check and release.
    task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ed, input logic ec);
        exp_t e;
        int   l1, l8;
        req_op = op; req_porta = a; req_portb = b; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req_porta = $urandom; req_portb = $urandom; req_op = 4'($urandom);
        e.data = ed; e.cond = ec;
        e.lat = exp_lat(op, a, 1); q1.push_back(e);
        e.lat = exp_lat(op, a, 8); q8.push_back(e);
        chk({nm, " req_ready1 busy"}, 32'(req_ready1), 32'd0);
        chk({nm, " req_ready8 busy"}, 32'(req_ready8), 32'd0);
        l1 = -1; l8 = -1;
        for (int j = 0; j < 80; j++) begin
            if (res_valid1 && l1 < 0) l1 = j + 1;
            if (res_valid8 && l8 < 0) l8 = j + 1;
            if (l1 >= 0 && l8 >= 0) break;
            tick();
        end
        e = q1.pop_front();
        chk({nm, " lat1"}, 32'(l1), 32'(e.lat));
        chk({nm, " data1"}, res_data1, e.data);
        chk({nm, " cond1"}, 32'(res_cond1), 32'(e.cond));
        e = q8.pop_front();
        chk({nm, " lat8"}, 32'(l8), 32'(e.lat));
        chk({nm, " data8"}, res_data8, e.data);
        chk({nm, " cond8"}, 32'(res_cond8), 32'(e.cond));
        handshake(nm);
    endtask

    initial begin
        tbl[0]  = '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
        tbl[1]  = '{OP_SUB,  32'h0000_0003, 32'h0000_000A, 32'h0000_0007, 1'b0};
        tbl[2]  = '{OP_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0};
        tbl[3]  = '{OP_OR,   32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0};
        tbl[4]  = '{OP_XOR,  32'h0000_AAAA, 32'h0000_AAAA, 32'h0000_0000, 1'b1};
        tbl[5]  = '{OP_NOT,  32'h0000_0000, 32'h0000_0123, 32'hFFFF_FFFF, 1'b0};
        tbl[6]  = '{OP_NOP,  32'h0000_0005, 32'h0000_0009, 32'h0000_0005, 1'b0};
        tbl[7]  = '{OP_SLT,  32'h0000_0001, 32'h8000_0000, 32'h0000_0001, 1'b1};
        tbl[8]  = '{OP_SLTU, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 1'b0};
        tbl[9]  = '{OP_EQ,   32'h0000_1234, 32'h0000_1234, 32'h0000_0001, 1'b1};
        tbl[10] = '{4'd14,   32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b0};
        tbl[11] = '{OP_SRA,  32'h0000_001F, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0};
        tbl[12] = '{OP_SLL,  32'h0000_0020, 32'h0000_ABCD, 32'h0000_ABCD, 1'b0};
        tbl[13] = '{OP_SRL,  32'h0000_000D, 32'hF000_0000, 32'h0007_8000, 1'b0};
        tbl[14] = '{OP_SLL,  32'hFFFF_FFE1, 32'h0000_0003, 32'h0000_0006, 1'b0};
        tbl[15] = '{OP_SRL,  32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1};

        #12;
        chk("rst res_valid1", 32'(res_valid1), 32'd0);
        chk("rst res_data1",  res_data1, 32'd0);
        chk("rst res_cond1",  32'(res_cond1), 32'd0);
        chk("rst req_ready1", 32'(req_ready1), 32'd1);
        chk("rst res_valid8", 32'(res_valid8), 32'd0);
        chk("rst req_ready8", 32'(req_ready8), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 16; i++)
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ed, tbl[i].ec);

        // Backpressure: result holds and new requests are refused while in DONE.
        req_op = OP_ADD; req_porta = 32'd20; req_portb = 32'd22; req_valid = 1'b1;
        tick();
        req_op = OP_SUB; req_porta = 32'd1; req_portb = 32'd100;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp res_valid1", 32'(res_valid1), 32'd1);
            chk("bp res_data1",  res_data1, 32'd42);
            chk("bp req_ready1", 32'(req_ready1), 32'd0);
            chk("bp res_data8",  res_data8, 32'd42);
            chk("bp req_ready8", 32'(req_ready8), 32'd0);
        end
        req_valid = 1'b0;
        handshake("bp");
        tick();
        chk("bp no extra res1", 32'(res_valid1), 32'd0);
        chk("bp no extra res8", 32'(res_valid8), 32'd0);

        // Reset in the middle of a 20-bit shift discards the operation.
        req_op = OP_SLL; req_porta = 32'd20; req_portb = 32'd1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk("mid rst res_valid1", 32'(res_valid1), 32'd0);
        chk("mid rst req_ready1", 32'(req_ready1), 32'd1);
        chk("mid rst res_valid8", 32'(res_valid8), 32'd0);
        chk("mid rst req_ready8", 32'(req_ready8), 32'd1);
        req_op = OP_ADD; req_porta = 32'd1; req_portb = 32'd1; req_valid = 1'b1;
        tick(); tick();
        chk("in rst res_valid1", 32'(res_valid1), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post rst res_valid1", 32'(res_valid1), 32'd0);
        chk("post rst res_valid8", 32'(res_valid8), 32'd0);
        run_op("post rst add", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
